cdc_sync_filt: RTL and testbench

Multi-channel, parametrised-depth synchroniser for asynchronous single-bit inputs (status lines, buttons, external flags) entering the `clk` domain. Each channel passes through an N-stage metastability chain. A per-channel runtime-programmable glitch filter follows the chain. Registered rise/fall event pulses are generated on every committed transition. This block replaces the fixed 2-stage bus synchroniser wherever inputs are independent, may bounce, or need edge events.

---
 rtl/cdc_sync_filt.sv | 93 +++++++++
 tb/tb_cdc_sync_filt.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cdc_sync_filt.sv
// cdc_sync_filt
//   Multi-channel synchroniser for independent asynchronous single-bit inputs.
//   Each channel runs through a STAGES-deep metastability chain, then a glitch
//   filter that commits a new level only after the synchronised input has
//   differed from the committed level on filt_len+1 consecutive edges.
//   Every commit produces a registered one-cycle rise or fall pulse.
//
// Ports
//   clk       sampling / system clock
//   rst       synchronous, active-high reset
//   din       [CH]     asynchronous inputs (no timing relation to clk)
//   filt_len  [FILT_W] glitch threshold, quasi-static, shared by all channels
//   dout      [CH]     filtered, synchronised level
//   rise      [CH]     one-cycle pulse on a committed 0->1 transition
//   fall      [CH]     one-cycle pulse on a committed 1->0 transition
//   chg                OR of all rise/fall bits
module cdc_sync_filt #(
  parameter int            CH      = 8,
  parameter int            STAGES  = 2,
  parameter int            FILT_W  = 4,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     din,
  input  logic [FILT_W-1:0] filt_len,
  output logic [CH-1:0]     dout,
  output logic [CH-1:0]     rise,
  output logic [CH-1:0]     fall,
  output logic              chg
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("cdc_sync_filt: STAGES must be at least 2");
    end
  endgenerate

  // Synchroniser chain: sync_p0[0] samples din, sync_p0[STAGES-1] is the
  // synchronised level. Flops only, nothing in between.
  (* ASYNC_REG = "TRUE" *) logic [CH-1:0] sync_p0 [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) sync_p0[k] <= RST_VAL;
    end else begin
      sync_p0[0] <= din;
      for (int k = 1; k < STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  logic [CH-1:0] s_p0;
  assign s_p0 = sync_p0[STAGES-1];

  // Glitch filter and event generation.
  // The >= comparison means a threshold lowered below an in-flight count
  // commits on the next edge; the count never exceeds filt_len, so it never
  // wraps.
  logic [CH-1:0]     lvl_p1;
  logic [CH-1:0]     rise_p1;
  logic [CH-1:0]     fall_p1;
  logic [FILT_W-1:0] cnt_p1 [CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_p1  <= RST_VAL;
      rise_p1 <= '0;
      fall_p1 <= '0;
      for (int i = 0; i < CH; i++) cnt_p1[i] <= '0;
    end else begin
      rise_p1 <= '0;
      fall_p1 <= '0;
      for (int i = 0; i < CH; i++) begin
        if (s_p0[i] == lvl_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] >= filt_len) begin
          lvl_p1[i]  <= s_p0[i];
          cnt_p1[i]  <= '0;
          rise_p1[i] <= s_p0[i];
          fall_p1[i] <= ~s_p0[i];
        end else begin
          cnt_p1[i] <= cnt_p1[i] + 1'b1;
        end
      end
    end
  end

  assign dout = lvl_p1;
  assign rise = rise_p1;
  assign fall = fall_p1;
  assign chg  = |(rise_p1 | fall_p1);

endmodule

// File: tb/tb_cdc_sync_filt.sv
// Directed bench for cdc_sync_filt with CH=4, STAGES=2, FILT_W=4,
// RST_VAL=4'b1000. Each row drives inputs for one clock edge and lists the
// outputs expected right after that edge.
module tb_cdc_sync_filt;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] filt_len;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       chg;

  cdc_sync_filt #(
    .CH      (4),
    .STAGES  (2),
    .FILT_W  (4),
    .RST_VAL (4'b1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .filt_len (filt_len),
    .dout     (dout),
    .rise     (rise),
    .fall     (fall),
    .chg      (chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] d;
    logic [3:0] fl;
    logic [3:0] edout;
    logic [3:0] erise;
    logic [3:0] efall;
  } vec_t;

  vec_t tbl[$];
  int   vecs    = 0;
  int   miscmp  = 0;
  int   row     = 0;

  function automatic void add(input logic r, input logic [3:0] d, input logic [3:0] fl,
                              input logic [3:0] ed, input logic [3:0] er, input logic [3:0] ef);
    vec_t v;
    v.r = r; v.d = d; v.fl = fl; v.edout = ed; v.erise = er; v.efall = ef;
    tbl.push_back(v);
  endfunction

  function automatic void addn(input int n, input logic r, input logic [3:0] d,
                               input logic [3:0] fl, input logic [3:0] ed,
                               input logic [3:0] er, input logic [3:0] ef);
    for (int k = 0; k < n; k++) add(r, d, fl, ed, er, ef);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  // Drive one edge's inputs, clock, and compare the registered outputs.
  task automatic step(input logic r, input logic [3:0] d, input logic [3:0] fl,
                      input logic [3:0] ed, input logic [3:0] er, input logic [3:0] ef);
    logic [3:0] echg;
    rst = r; din = d; filt_len = fl;
    @(posedge clk);
    #1;
    row++;
    echg = {3'b000, |(er | ef)};
    chk("dout", row, dout, ed);
    chk("rise", row, rise, er);
    chk("fall", row, fall, ef);
    chk("chg",  row, {3'b000, chg}, echg);
  endtask

  initial begin
    rst = 1'b1; din = 4'b0000; filt_len = 4'd3;

    // Reset with arbitrary inputs, then quiet release at the reset level.
    add(1, 4'b0111, 4'd3, 4'b1000, 4'b0000, 4'b0000);
    add(1, 4'b0101, 4'd3, 4'b1000, 4'b0000, 4'b0000);
    add(1, 4'b1010, 4'd3, 4'b1000, 4'b0000, 4'b0000);
    addn(20, 0, 4'b1000, 4'd3, 4'b1000, 4'b0000, 4'b0000);

    // Nominal latency, filt_len=3: commit at edge 6.
    addn(5, 0, 4'b1001, 4'd3, 4'b1000, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'd3, 4'b1001, 4'b0001, 4'b0000);
    addn(2, 0, 4'b1001, 4'd3, 4'b1001, 4'b0000, 4'b0000);

    // din[1] high for 3 cycles: rejected.
    addn(3, 0, 4'b1011, 4'd3, 4'b1001, 4'b0000, 4'b0000);
    addn(5, 0, 4'b1001, 4'd3, 4'b1001, 4'b0000, 4'b0000);

    // din[1] high for 4 cycles: rise at edge 6, fall at edge 10.
    addn(4, 0, 4'b1011, 4'd3, 4'b1001, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'd3, 4'b1001, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'd3, 4'b1011, 4'b0010, 4'b0000);
    addn(3, 0, 4'b1001, 4'd3, 4'b1011, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'd3, 4'b1001, 4'b0000, 4'b0010);
    add(0, 4'b1001, 4'd3, 4'b1001, 4'b0000, 4'b0000);

    // Pass-through, filt_len=0: din[2] rises, commit at edge 3.
    addn(2, 0, 4'b1101, 4'd0, 4'b1001, 4'b0000, 4'b0000);
    add(0, 4'b1101, 4'd0, 4'b1101, 4'b0100, 4'b0000);
    add(0, 4'b1101, 4'd0, 4'b1101, 4'b0000, 4'b0000);
    // Bring din[2] back low, still pass-through.
    addn(2, 0, 4'b1001, 4'd0, 4'b1101, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'd0, 4'b1001, 4'b0000, 4'b0100);
    add(0, 4'b1001, 4'd0, 4'b1001, 4'b0000, 4'b0000);

    // Simultaneous din[2] 0->1 and din[3] 1->0, filt_len=2: both at edge 5.
    addn(4, 0, 4'b0101, 4'd2, 4'b1001, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'd2, 4'b0101, 4'b0100, 4'b1000);
    add(0, 4'b0101, 4'd2, 4'b0101, 4'b0000, 4'b0000);

    foreach (tbl[i])
      step(tbl[i].r, tbl[i].d, tbl[i].fl, tbl[i].edout, tbl[i].erise, tbl[i].efall);

    // Drop din[0] with filt_len=0 to set up the mid-count scenarios.
    repeat (2) step(0, 4'b0100, 4'd0, 4'b0101, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'd0, 4'b0100, 4'b0000, 4'b0001);
    step(0, 4'b0100, 4'd0, 4'b0100, 4'b0000, 4'b0000);

    // filt_len=10, din[0] high; after 7 edges cnt[0]=5, then reset.
    repeat (7) step(0, 4'b0101, 4'd10, 4'b0100, 4'b0000, 4'b0000);
    step(1, 4'b0101, 4'd10, 4'b1000, 4'b0000, 4'b0000);
    // Count restarts from the reset level: commit 13 edges after release
    // (channels 0, 2 and 3 all differ from RST_VAL).
    repeat (12) step(0, 4'b0101, 4'd10, 4'b1000, 4'b0000, 4'b0000);
    step(0, 4'b0101, 4'd10, 4'b0101, 4'b0101, 4'b1000);
    step(0, 4'b0101, 4'd10, 4'b0101, 4'b0000, 4'b0000);

    // Lower filt_len 10 -> 2 while cnt[0]=5: commit on the next edge.
    repeat (7) step(0, 4'b0100, 4'd10, 4'b0101, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'd2, 4'b0100, 4'b0000, 4'b0001);
    step(0, 4'b0100, 4'd2, 4'b0100, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
